// File: rtl/roic_frame_scanner.sv
// ROIC readout sequencer: fsync pulse, integration window, then raster-order
// one-hot row/column strobes with a binary pixel address for the ADC capture.
module roic_frame_scanner #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  parameter int IW   = 8,
  parameter int GW   = 4,
  parameter int FCW  = 8,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            clk,
  input  logic            master_rst_n,
  input  logic            start,
  input  logic            cont_mode,
  input  logic            abort,
  input  logic [IW-1:0]   intg_len,
  input  logic [GW-1:0]   col_gap,
  output logic            fsync,
  output logic            intg,
  output logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic            pix_valid,
  output logic [RW-1:0]   pix_row,
  output logic [CLW-1:0]  pix_col,
  output logic            busy,
  output logic            frame_done,
  output logic [FCW-1:0]  frame_cnt
);

  localparam int CW = (IW > GW) ? IW : GW;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FSYNC   = 3'd1;
  localparam logic [2:0] S_INTG    = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;
  localparam logic [2:0] S_ROW_END = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]    state, state_n;
  logic [RW-1:0] r_idx, r_n;
  logic [CLW-1:0] c_idx, c_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gap_len, gap_len_n;

  // cnt holds the remaining cycles of the current INTG or GAP stretch minus one
  always_comb begin
    state_n   = state;
    r_n       = r_idx;
    c_n       = c_idx;
    cnt_n     = cnt;
    gap_len_n = gap_len;
    case (state)
      S_IDLE: begin
        if (start || cont_mode) state_n = S_FSYNC;
      end
      S_FSYNC: begin
        gap_len_n = col_gap;
        cnt_n     = (intg_len == '0) ? '0 : CW'(intg_len - IW'(1));
        state_n   = S_INTG;
      end
      S_INTG: begin
        if (cnt == '0) begin
          state_n = S_STROBE;
          r_n     = '0;
          c_n     = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_STROBE: begin
        if (c_idx == CLW'(COLS - 1)) begin
          state_n = S_ROW_END;
        end else if (gap_len != '0) begin
          state_n = S_GAP;
          cnt_n   = CW'(gap_len - GW'(1));
        end else begin
          c_n = c_idx + CLW'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n = S_STROBE;
          c_n     = c_idx + CLW'(1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_ROW_END: begin
        if (r_idx == RW'(ROWS - 1)) begin
          state_n = S_DONE;
        end else begin
          state_n = S_STROBE;
          r_n     = r_idx + RW'(1);
          c_n     = '0;
        end
      end
      S_DONE: begin
        state_n = cont_mode ? S_FSYNC : S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // abort also holds IDLE, which is what swallows a simultaneous start
    if (abort) state_n = S_IDLE;
  end

  // Outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      state      <= S_IDLE;
      r_idx      <= '0;
      c_idx      <= '0;
      cnt        <= '0;
      gap_len    <= '0;
      fsync      <= 1'b0;
      intg       <= 1'b0;
      row        <= '0;
      col        <= '0;
      pix_valid  <= 1'b0;
      pix_row    <= '0;
      pix_col    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_n;
      r_idx      <= r_n;
      c_idx      <= c_n;
      cnt        <= cnt_n;
      gap_len    <= gap_len_n;
      fsync      <= (state_n == S_FSYNC);
      intg       <= (state_n == S_INTG);
      row        <= (state_n == S_STROBE || state_n == S_GAP) ? (ROWS'(1) << r_n) : '0;
      col        <= (state_n == S_STROBE) ? (COLS'(1) << c_n) : '0;
      pix_valid  <= (state_n == S_STROBE);
      pix_row    <= (state_n == S_STROBE) ? r_n : '0;
      pix_col    <= (state_n == S_STROBE) ? c_n : '0;
      busy       <= (state_n != S_IDLE);
      frame_done <= (state_n == S_DONE);
      if (state_n == S_DONE) frame_cnt <= frame_cnt + FCW'(1);
    end
  end

endmodule

// File: tb/tb_roic_frame_scanner.sv
// Scoreboard bench for roic_frame_scanner: a default 3x3 instance and a 1x8
// instance with a 2-bit frame counter; a negedge monitor pops expected events.
module tb_roic_frame_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       master_rst_n = 1'b0;
  logic       start = 1'b0, cont_mode = 1'b0, abort = 1'b0;
  logic [7:0] intg_len = 8'd0;
  logic [3:0] col_gap = 4'd0;
  logic       fsync, intg, pix_valid, busy, frame_done;
  logic [2:0] row, col;
  logic [1:0] pix_row, pix_col;
  logic [7:0] frame_cnt;

  logic       start2 = 1'b0, cont2 = 1'b0, abort2 = 1'b0;
  logic [7:0] intg_len2 = 8'd0;
  logic [3:0] col_gap2 = 4'd0;
  logic       fsync2, intg2, pix_valid2, busy2, frame_done2;
  logic [0:0] row2, pix_row2;
  logic [7:0] col2;
  logic [2:0] pix_col2;
  logic [1:0] frame_cnt2;

  roic_frame_scanner u_dut (
    .clk(clk), .master_rst_n(master_rst_n), .start(start), .cont_mode(cont_mode),
    .abort(abort), .intg_len(intg_len), .col_gap(col_gap), .fsync(fsync), .intg(intg),
    .row(row), .col(col), .pix_valid(pix_valid), .pix_row(pix_row), .pix_col(pix_col),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  roic_frame_scanner #(.ROWS(1), .COLS(8), .FCW(2)) u_dut2 (
    .clk(clk), .master_rst_n(master_rst_n), .start(start2), .cont_mode(cont2),
    .abort(abort2), .intg_len(intg_len2), .col_gap(col_gap2), .fsync(fsync2), .intg(intg2),
    .row(row2), .col(col2), .pix_valid(pix_valid2), .pix_row(pix_row2), .pix_col(pix_col2),
    .busy(busy2), .frame_done(frame_done2), .frame_cnt(frame_cnt2)
  );

  typedef struct {int cyc; int r; int c;} pix_t;
  typedef struct {int cyc; int cnt;} done_t;

  pix_t  pq1[$], pq2[$];
  done_t dq1[$], dq2[$];
  int    fs_q[$];
  int    cyc = 0;
  int    total = 0, bad = 0;
  int    intg_n = 0, last_done = -1;
  int    cs;
  pix_t  e1, e2;
  done_t d1, d2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    master_rst_n = 1'b0;
    tick(2);
    master_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic clear_track();
    fs_q.delete();
    intg_n    = 0;
    last_done = -1;
  endtask

  task automatic apply_stimulus(logic s, logic cm, logic ab, int len, int gap);
    start     = s;
    cont_mode = cm;
    abort     = ab;
    intg_len  = 8'(len);
    col_gap   = 4'(gap);
  endtask

  // Expected pixel/done cycles for a frame whose fsync is seen at cycle fs
  task automatic push_frame(int dut, int fs, int len, int gap, int rows, int cols,
                            int n_pix, int cnt);
    int first  = fs + 1 + len;
    int rowlen = cols + (cols - 1) * gap + 1;
    int n      = 0;
    pix_t  p;
    done_t d;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (n < n_pix) begin
          p.cyc = first + r * rowlen + c * (gap + 1);
          p.r   = r;
          p.c   = c;
          if (dut == 1) pq1.push_back(p); else pq2.push_back(p);
          n++;
        end
      end
    end
    if (cnt >= 0) begin
      d.cyc = first + rows * rowlen;
      d.cnt = cnt;
      if (dut == 1) dq1.push_back(d); else dq2.push_back(d);
    end
  endtask

  always @(negedge clk) begin
    if (master_rst_n) begin
      check_output("dut1_invariant", int'(!(intg && (row != 3'b0)) &&
        !((col != 3'b0) && (row == 3'b0)) && $onehot0(row) && $onehot0(col) &&
        (pix_valid == (col != 3'b0)) && (pix_valid || (pix_row == 2'b0 && pix_col == 2'b0))), 1);
      if (pix_valid) begin
        if (pq1.size() == 0) check_output("dut1_unexpected_pix", cyc, -1);
        else begin
          e1 = pq1.pop_front();
          check_output("dut1_pix_cycle", cyc, e1.cyc);
          check_output("dut1_row", int'(row), 1 << e1.r);
          check_output("dut1_col", int'(col), 1 << e1.c);
          check_output("dut1_pix_row", int'(pix_row), e1.r);
          check_output("dut1_pix_col", int'(pix_col), e1.c);
        end
      end
      if (frame_done) begin
        last_done = cyc;
        if (dq1.size() == 0) check_output("dut1_unexpected_done", cyc, -1);
        else begin
          d1 = dq1.pop_front();
          check_output("dut1_done_cycle", cyc, d1.cyc);
          check_output("dut1_frame_cnt", int'(frame_cnt), d1.cnt);
        end
      end
      if (fsync) fs_q.push_back(cyc);
      if (intg) intg_n++;

      check_output("dut2_invariant", int'(!(intg2 && row2[0]) && $onehot0(col2) &&
        (pix_valid2 == (col2 != 8'b0)) && !((col2 != 8'b0) && !row2[0])), 1);
      if (pix_valid2) begin
        if (pq2.size() == 0) check_output("dut2_unexpected_pix", cyc, -1);
        else begin
          e2 = pq2.pop_front();
          check_output("dut2_pix_cycle", cyc, e2.cyc);
          check_output("dut2_col", int'(col2), 1 << e2.c);
          check_output("dut2_pix_col", int'(pix_col2), e2.c);
        end
      end
      if (frame_done2) begin
        if (dq2.size() == 0) check_output("dut2_unexpected_done", cyc, -1);
        else begin
          d2 = dq2.pop_front();
          check_output("dut2_done_cycle", cyc, d2.cyc);
          check_output("dut2_frame_cnt", int'(frame_cnt2), d2.cnt);
        end
      end
    end
  end

  initial begin
    // reset state, then async reset in the middle of integration
    tick(1);
    check_output("reset_outputs", int'({fsync, intg, row, col, pix_valid, pix_row, pix_col,
                                        busy, frame_done, frame_cnt}), 0);
    apply_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 10, 5);
    tick(1);
    start = 1'b0;
    tick(3);
    check_output("mid_intg_busy", int'({busy, intg}), 3);
    #3 master_rst_n = 1'b0;
    #1 check_output("async_reset_clear", int'({fsync, intg, row, col, pix_valid, pix_row,
                                               pix_col, busy, frame_done, frame_cnt}), 0);
    tick(2);
    master_rst_n = 1'b1;
    tick(2);
    check_output("busy_after_release", int'(busy), 0);

    // L=10, G=5 single frame: done at frame cycle 54
    apply_reset();
    clear_track();
    cs = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 10, 5);
    push_frame(1, cs + 1, 10, 5, 3, 3, 9, 1);
    tick(1);
    start = 1'b0;
    tick(60);
    check_output("l10_fsync_count", fs_q.size(), 1);
    check_output("l10_fsync_cycle", (fs_q.size() > 0) ? fs_q[0] - cs : -1, 1);
    check_output("l10_intg_len", intg_n, 10);
    check_output("l10_done_cycle", last_done - cs, 54);
    check_output("l10_frame_cnt", int'(frame_cnt), 1);
    check_output("l10_busy_low", int'(busy), 0);

    // L=0 behaves as 1, G=0 gives back-to-back strobes, 15-cycle frame
    apply_reset();
    clear_track();
    cs = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0);
    push_frame(1, cs + 1, 1, 0, 3, 3, 9, 1);
    tick(1);
    start = 1'b0;
    tick(20);
    check_output("l0_intg_len", intg_n, 1);
    check_output("l0_done_cycle", last_done - cs, 15);
    check_output("l0_frame_cnt", int'(frame_cnt), 1);

    // continuous mode for 3 frames of 22 cycles (L=2, G=1)
    apply_reset();
    clear_track();
    cs = cyc;
    apply_stimulus(1'b0, 1'b1, 1'b0, 2, 1);
    for (int k = 0; k < 3; k++) push_frame(1, cs + 1 + 22 * k, 2, 1, 3, 3, 9, k + 1);
    tick(45);
    cont_mode = 1'b0;
    tick(30);
    check_output("cont_fsync_count", fs_q.size(), 3);
    check_output("cont_fsync2", (fs_q.size() > 1) ? fs_q[1] - cs : -1, 23);
    check_output("cont_fsync3", (fs_q.size() > 2) ? fs_q[2] - cs : -1, 45);
    check_output("cont_last_done", last_done - cs, 66);
    check_output("cont_frame_cnt", int'(frame_cnt), 3);
    check_output("cont_idle", int'(busy), 0);

    // abort on the 5th strobe, with start held through the abort and the idle cycle after
    clear_track();
    cs = cyc;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1, 0);
    push_frame(1, cs + 1, 1, 0, 3, 3, 5, -1);
    tick(1);
    start = 1'b0;
    tick(7);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    check_output("abort_idle", int'({busy, row, col, pix_valid}), 0);
    tick(1);
    check_output("abort_blocks_start", int'(busy), 0);
    start = 1'b0;
    abort = 1'b0;
    tick(10);
    check_output("abort_still_idle", int'(busy), 0);
    check_output("abort_no_done", last_done, -1);
    check_output("abort_fsync_count", fs_q.size(), 1);
    check_output("abort_frame_cnt", int'(frame_cnt), 3);

    // 1x8 instance, continuous, 12-cycle frames, 2-bit counter wraps 3->0
    apply_reset();
    clear_track();
    cs = cyc;
    intg_len2 = 8'd0;
    col_gap2  = 4'd0;
    cont2     = 1'b1;
    for (int k = 0; k < 5; k++) push_frame(2, cs + 1 + 12 * k, 1, 0, 1, 8, 8, (k + 1) % 4);
    tick(50);
    cont2 = 1'b0;
    tick(20);
    check_output("wide_frame_cnt", int'(frame_cnt2), 1);
    check_output("wide_idle", int'(busy2), 0);

    check_output("dut1_pix_pending", pq1.size(), 0);
    check_output("dut1_done_pending", dq1.size(), 0);
    check_output("dut2_pix_pending", pq2.size(), 0);
    check_output("dut2_done_pending", dq2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
